// File: rtl/regfile_pkg.sv
// Shared constants for the register file and its companion ALU:
// datapath width, address width, entry count and the ALU opcode map.
package regfile_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    localparam logic [4:0] OP_AND = 5'h00;
    localparam logic [4:0] OP_ADD = 5'h01;
    localparam logic [4:0] OP_SUB = 5'h02;
    localparam logic [4:0] OP_OR  = 5'h03;
    localparam logic [4:0] OP_XOR = 5'h04;
    localparam logic [4:0] OP_SLL = 5'h05;
    localparam logic [4:0] OP_SRL = 5'h06;
    localparam logic [4:0] OP_SRA = 5'h07;
    localparam logic [4:0] OP_SLT = 5'h08;

endpackage

// File: rtl/regfile_alu.sv
// Combinational ALU used alongside the register file.
// Shifts use b[4:0]; ADD/SUB wrap modulo 2^32; SLT is signed and
// yields 1/0; unassigned opcodes produce zero.
module alu
    import regfile_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        op,
    output logic [DATA_W-1:0] y
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    // Opcode decode; anything outside the map falls through to zero
    always_comb begin
        y = '0;
        case (op)
            OP_AND: y = a & b;
            OP_ADD: y = a + b;
            OP_SUB: y = a - b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_SLL: y = a << shamt;
            OP_SRL: y = a >> shamt;
            OP_SRA: y = DATA_W'($signed(a) >>> shamt);
            OP_SLT: y = ($signed(a) < $signed(b)) ? DATA_W'(1) : '0;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/regfile.sv
// 64 x 32 register file: one combinational read port, one synchronous
// write port, asynchronous active-high clear of every entry.
// Optional feature: define REGFILE_BYPASS_EN to forward wdata onto
// rdata in the same cycle when a write targets the address being read.
// Reset always wins: rdata is zero while rst is high, bypass or not.
module regfile
    import regfile_pkg::*;
#(
    parameter int DEPTH = regfile_pkg::DEPTH,
    parameter int AW    = regfile_pkg::ADDR_W
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              we
);

    logic [DEPTH-1:0][DATA_W-1:0] mem;

    // Storage: async clear has priority, otherwise single-port write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read mux, gated to zero during reset, with optional forwarding
    always_comb begin
        rdata = mem[raddr];
`ifdef REGFILE_BYPASS_EN
        if (we && (waddr == raddr))
            rdata = wdata;
`endif
        if (rst)
            rdata = '0;
    end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile plus the companion alu.
// Reference model: a plain array of 64 words updated at each clock edge,
// and an ALU model computed with ordinary integer arithmetic.
`timescale 1ns/1ps
module tb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  raddr, waddr;
    logic [31:0] rdata, wdata;
    logic        we;

    logic [31:0] a, b, y;
    logic [4:0]  op;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] model [64];

    regfile dut (
        .clk   (clk),
        .rst   (rst),
        .raddr (raddr),
        .rdata (rdata),
        .waddr (waddr),
        .wdata (wdata),
        .we    (we)
    );

    alu u_alu (
        .a  (a),
        .b  (b),
        .op (op),
        .y  (y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h want %08h", tag, got, exp);
        end
    endtask

    // Expected read value before the edge, given the current inputs
    function automatic logic [31:0] rd_exp();
        logic [31:0] v;
        v = model[raddr];
`ifdef REGFILE_BYPASS_EN
        if (we && waddr == raddr) v = wdata;
`endif
        if (rst) v = 32'h0;
        return v;
    endfunction

    // Advance one clock; model commits the pending write at the edge
    task automatic tick();
        @(posedge clk);
        if (!rst && we) model[waddr] = wdata;
        #1;
    endtask

    task automatic wr(input logic [5:0] ad, input logic [31:0] d);
        we = 1'b1; waddr = ad; wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 64; i++) begin
            raddr = 6'(i);
            #0.05;
            chk(tag, rdata, model[i]);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [31:0] x, input logic [31:0] z, input logic [4:0] o);
        int sh;
        sh = int'(z % 32);
        case (o)
            5'h00: return x & z;
            5'h01: return 32'((longint'(x) + longint'(z)) % 64'h1_0000_0000);
            5'h02: return 32'((longint'(x) + 64'h1_0000_0000 - longint'(z)) % 64'h1_0000_0000);
            5'h03: return x | z;
            5'h04: return x ^ z;
            5'h05: return 32'(longint'(x) * (64'd1 << sh));
            5'h06: return 32'(longint'(x) / (64'd1 << sh));
            5'h07: return x[31] ? ~((~x) >> sh) : (x >> sh);
            5'h08: return (int'(x) < int'(z)) ? 32'd1 : 32'd0;
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        logic [31:0] pa, pb, d;
        longint unsigned s0, s1, s2;

        for (int i = 0; i < 64; i++) model[i] = 32'h0;
        rst = 1'b1; we = 1'b1; waddr = 6'd3; wdata = 32'hFFFF_FFFF; raddr = 6'd3;
        a = 0; b = 0; op = 0;

        // reset state, with a write attempted during reset
        tick(); tick();
        for (int i = 0; i < 64; i++) begin
            raddr = 6'(i); waddr = 6'(i);
            #0.05;
            chk("rst_read", rdata, 32'h0);
        end
        we = 1'b0; rst = 1'b0;
        tick();
        check_all("post_rst");

        // directed writes at address 5 and the top entry
        wr(6'd5, 32'hDEADBEEF);
        wr(6'd63, 32'h12345678);
        raddr = 6'd5;  #1; chk("addr5", rdata, 32'hDEADBEEF);
        raddr = 6'd63; #1; chk("addr63", rdata, 32'h12345678);
        check_all("others_zero");

        // we=0 must not modify
        we = 1'b0; waddr = 6'd5; wdata = 32'h0;
        tick();
        raddr = 6'd5; #1; chk("we0_hold", rdata, 32'hDEADBEEF);

        // same-address read/write before and after the edge
        raddr = 6'd7; we = 1'b1; waddr = 6'd7; wdata = 32'hA5A5A5A5;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("rw7_pre", rdata, 32'hA5A5A5A5);
`else
        chk("rw7_pre", rdata, 32'h0);
`endif
        tick();
        we = 1'b0; #1;
        chk("rw7_post", rdata, 32'hA5A5A5A5);

        // different-address read during write is undisturbed
        raddr = 6'd5; we = 1'b1; waddr = 6'd6; wdata = 32'h0BAD_F00D;
        #1; chk("rw_diff", rdata, 32'hDEADBEEF);
        tick(); we = 1'b0;

        // randomized traffic against the array model
        for (int n = 0; n < 400; n++) begin
            we    = 1'($urandom_range(0, 1));
            waddr = 6'($urandom_range(0, 63));
            raddr = ($urandom_range(0, 3) == 0) ? waddr : 6'($urandom_range(0, 63));
            wdata = $urandom;
            #1;
            chk("rand_rd", rdata, rd_exp());
            tick();
        end
        we = 1'b0;
        check_all("rand_final");

        // async reset between edges clears everything before the next edge
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 64; i++) begin
            raddr = 6'(i); waddr = 6'(i); we = 1'b1; wdata = $urandom;
            #0.1;
            chk("async_rst", rdata, 32'h0);
        end
        for (int i = 0; i < 64; i++) model[i] = 32'h0;
        tick();
        we = 1'b0; rst = 1'b0;
        tick(); tick();
        check_all("rst_mid_zero");

        // alu directed cases
        op = 5'h01; a = 32'd2;          b = 32'd2; #1; chk("alu_add", y, 32'd4);
        op = 5'h01; a = 32'hFFFF_FFFF;  b = 32'd1; #1; chk("alu_add_wrap", y, 32'h0);
        op = 5'h02; a = 32'h0;          b = 32'd1; #1; chk("alu_sub_wrap", y, 32'hFFFF_FFFF);
        op = 5'h08; a = 32'hFFFF_FFFF;  b = 32'd1; #1; chk("alu_slt", y, 32'd1);
        op = 5'h1F; a = 32'h1234_5678;  b = 32'd9; #1; chk("alu_bad_op", y, 32'h0);
        op = 5'h07; a = 32'h8000_0000;  b = 32'd4; #1; chk("alu_sra", y, 32'hF800_0000);

        // alu random sweep
        for (int n = 0; n < 300; n++) begin
            a = $urandom; b = $urandom;
            op = 5'($urandom_range(0, 31));
            if (n % 3 == 0) op = 5'($urandom_range(0, 8));
            #1;
            chk($sformatf("alu_op%02h", op), y, alu_ref(a, b, op));
        end

        // chain: addr0 = 2, then each entry = sum of the previous two values
        wr(6'd0, 32'd2);
        pb = 32'd2;
        for (int k = 1; k < 64; k++) begin
            raddr = 6'(k - 1);
            #1;
            pa = rdata;
            op = 5'h01; a = pa; b = pb;
            #1;
            d = y;
            wr(6'(k), d);
            pb = pa;
        end
        s1 = 2; s0 = 2;
        for (int k = 0; k < 64; k++) begin
            if (k == 0) s2 = 2;
            else begin
                s2 = (s1 + s0) % 64'h1_0000_0000;
                s0 = s1;
                s1 = s2;
            end
            if (k == 0) begin s1 = 2; s0 = 2; end
            raddr = 6'(k);
            #0.05;
            chk($sformatf("chain%0d", k), rdata, 32'(s2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit entries; fixed at 64 for this block.
REQ-002 Parameter AW, default 6, address width; equals log2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 raddr  input  6  read address.
REQ-006 rdata  output  32  read data.
REQ-007 waddr  input  6  write address.
REQ-008 wdata  input  32  write data.
REQ-009 we  input  1  write enable, active-high.

Function
REQ-010 Storage SHALL be 64 entries x 32 bits, all addresses 0..63 writable; no hardwired-zero entry.
REQ-011 Write SHALL occur on rising clk when we=1 and rst=0: mem[waddr] <= wdata.
REQ-012 we=0 SHALL leave every entry unchanged.
REQ-013 Read SHALL be combinational: rdata = mem[raddr], zero-cycle latency, no read enable.
REQ-014 A write becomes visible on rdata immediately after the clock edge that performs it, unless REGFILE_BYPASS_EN is defined.
REQ-015 Address 63 SHALL be a normal entry; no wrap or out-of-range behaviour exists because all 6-bit codes are valid.
REQ-016 Simultaneous read and write to different addresses SHALL NOT disturb the read value.

Reset
REQ-017 rst=1 SHALL clear all 64 entries to 32'h0 immediately, without waiting for clk.
REQ-018 rdata SHALL read 32'h0 for any raddr while rst=1.
REQ-019 A write attempted while rst=1 SHALL be discarded; reset has priority over we.
REQ-020 Deasserting rst mid-sequence SHALL leave all entries at zero until the first subsequent write.

Configuration
REQ-021 Macro REGFILE_BYPASS_EN defined: when we=1 and waddr==raddr, rdata SHALL equal wdata combinationally in the same cycle, before the edge.
REQ-022 Macro REGFILE_BYPASS_EN undefined: rdata SHALL always equal the stored mem[raddr] (old value until the edge).
REQ-023 rst=1 SHALL override the bypass, so rdata=0 during reset in both configurations.

Structure
REQ-024 A shared package SHALL hold DATA_W=32, ADDR_W=6, DEPTH=64 and the 5-bit ALU opcode constants.
REQ-025 The companion sub-module alu is combinational and used alongside regfile.
REQ-026 alu ports: a[31:0], b[31:0], op[4:0], y[31:0].
REQ-027 alu opcodes: 0x00 AND, 0x01 ADD, 0x02 SUB, 0x03 OR, 0x04 XOR, 0x05 SLL by b[4:0], 0x06 SRL, 0x07 SRA, 0x08 SLT signed (y=1/0).
REQ-028 Any other alu opcode SHALL give y=0.
REQ-029 ADD and SUB wrap modulo 2^32 with no carry or overflow flag.
REQ-030 regfile SHALL contain no arithmetic; only storage, mux and the optional bypass.

Verification
REQ-031 Assert rst between edges -> all 64 reads return 0 before the next clk edge.
REQ-032 Write 32'hDEADBEEF to addr 5, then 32'h12345678 to addr 63 -> read 5 gives DEADBEEF and read 63 gives 12345678; other addresses stay 0.
REQ-033 we=0 with waddr=5, wdata=0 -> addr 5 still reads DEADBEEF.
REQ-034 we=1, raddr=waddr=7, wdata=0xA5A5A5A5 before the edge -> rdata=A5A5A5A5 with REGFILE_BYPASS_EN; old value without it; A5A5A5A5 after the edge in both.
REQ-035 alu checks:
  - op 0x01, 2+2 -> 4
  - op 0x01, FFFFFFFF+1 -> 0
  - op 0x02, 0-1 -> FFFFFFFF
  - op 0x08, FFFFFFFF vs 1 -> 1
  - op 0x1F -> 0
REQ-036 Chain test: writes alu ADD results of the previous two values to addresses 1..63 in order, starting from 2 and 2 -> addr k reads the expected sequence 2, 4, 6, 10, 16, ... mod 2^32.
